uart_tx_fifo: RTL and testbench

Transmit-side byte buffer and launch controller that sits directly upstream of the UART transmitter. It accepts bytes from the system side through a write strobe and stores them in a synchronous FIFO. It then feeds them one at a time to the transmitter's `tx_din`/`tx_start` inputs, waiting for the transmitter's `tx_done_tick` between frames. It gives software/bus logic fire-and-forget byte writes and back-to-back frames on the line.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_fifo_if.sv | 31 +++
 rtl/uart_sync_fifo.sv | 67 ++++++
 rtl/uart_tx_fifo.sv | 75 +++++++
 tb/tb_uart_tx_fifo.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default data width, FIFO depth and the TX launch FSM encoding.
// Both the transmit-side and receive-side FIFOs import this package.
package uart_pkg;

  localparam int unsigned UART_DBITS  = 8;
  localparam int unsigned UART_ADDR_W = 4;

  typedef enum logic {
    TXF_IDLE = 1'b0,
    TXF_BUSY = 1'b1
  } txf_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bundle of signals between system logic, the TX byte buffer and the UART transmitter.
// The master side writes bytes and returns done ticks; the slave side is the buffer.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned DBITS  = UART_DBITS,
  parameter int unsigned ADDR_W = UART_ADDR_W
);

  logic              wr_en;
  logic [DBITS-1:0]  wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              tx_start;
  logic [DBITS-1:0]  tx_din;
  logic              tx_done_tick;
  logic              tx_busy;

  modport master (
    output wr_en, wr_data, tx_done_tick,
    input  full, empty, count, overflow, tx_start, tx_din, tx_busy
  );

  modport slave (
    input  wr_en, wr_data, tx_done_tick,
    output full, empty, count, overflow, tx_start, tx_din, tx_busy
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO with occupancy counter; pushes into a full FIFO are dropped,
// pops of an empty FIFO are ignored. Shared by the TX and RX byte buffers.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DBITS  = UART_DBITS,
  parameter int unsigned ADDR_W = UART_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DBITS-1:0]  push_data,
  input  logic              pop,
  output logic [DBITS-1:0]  head_c,
  output logic              drop_c,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned CW    = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DBITS-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok_c;
  logic              pop_ok_c;
  logic [CW-1:0]     count_nxt_c;

  // Full refuses writes even when a pop happens in the same cycle.
  always_comb begin
    push_ok_c   = push && !full;
    pop_ok_c    = pop && !empty;
    drop_c      = push && full;
    count_nxt_c = count;
    if (push_ok_c && !pop_ok_c) begin
      count_nxt_c = count + CW'(1);
    end else if (!push_ok_c && pop_ok_c) begin
      count_nxt_c = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count_nxt_c;
      full  <= (count_nxt_c == CW'(DEPTH));
      empty <= (count_nxt_c == '0);
    end
  end

  // Storage needs no reset; only slots behind the write pointer are ever read.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= push_data;
  end

  assign head_c = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer plus launch controller: pops queued bytes into tx_din and pulses
// tx_start, waiting for the transmitter's done tick between frames.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DBITS  = UART_DBITS,
  parameter int unsigned ADDR_W = UART_ADDR_W
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  txf_state_e       state;
  logic             pop_c;
  logic             drop_c;
  logic [DBITS-1:0] head_c;

  uart_sync_fifo #(
    .DBITS  (DBITS),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop_c),
    .head_c    (head_c),
    .drop_c    (drop_c),
    .full      (bus.full),
    .empty     (bus.empty),
    .count     (bus.count)
  );

  // A done tick right after a launch is not honoured, so tx_start never fires back-to-back.
  always_comb begin
    pop_c = 1'b0;
    if (!bus.empty) begin
      pop_c = (state == TXF_IDLE) || (bus.tx_done_tick && !bus.tx_start);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= TXF_IDLE;
      bus.tx_start <= 1'b0;
      bus.tx_din   <= '0;
      bus.tx_busy  <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.tx_start <= pop_c;
      if (drop_c) bus.overflow <= 1'b1;
      if (pop_c)  bus.tx_din   <= head_c;
      case (state)
        TXF_IDLE: begin
          if (pop_c) begin
            state       <= TXF_BUSY;
            bus.tx_busy <= 1'b1;
          end
        end
        TXF_BUSY: begin
          if (bus.tx_done_tick && bus.empty) begin
            state       <= TXF_IDLE;
            bus.tx_busy <= 1'b0;
          end
        end
        default: begin
          state       <= TXF_IDLE;
          bus.tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a queue-based model checked every cycle plus literal
// expectations for the single-byte, burst, fill/overflow, wrap, simultaneous and reset cases.
module tb_uart_tx_fifo;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  bit   chk_en;
  int   maxcnt;

  uart_tx_fifo_if #(.DBITS(8), .ADDR_W(4)) bus();

  uart_tx_fifo #(.DBITS(8), .ADDR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: bytes waiting in the buffer, line status and the last launch.
  logic [7:0] mq[$];
  bit         m_busy;
  bit         m_start;
  logic [7:0] m_din;
  bit         m_ovf;
  logic [7:0] got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_busy  = 1'b0;
      m_start = 1'b0;
      m_din   = 8'h00;
      m_ovf   = 1'b0;
    end else begin
      int sz;
      bit pop;
      sz  = mq.size();
      pop = (sz > 0) && (!m_busy || (bus.tx_done_tick && !m_start));
      if (bus.wr_en && sz == 16) m_ovf = 1'b1;
      if (pop) begin
        m_din   = mq.pop_front();
        m_start = 1'b1;
        m_busy  = 1'b1;
      end else begin
        m_start = 1'b0;
        if (m_busy && bus.tx_done_tick && sz == 0) m_busy = 1'b0;
      end
      if (bus.wr_en && sz < 16) mq.push_back(bus.wr_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc count",    32'(bus.count),    32'(mq.size()));
      chk("cyc full",     32'(bus.full),     32'(mq.size() == 16));
      chk("cyc empty",    32'(bus.empty),    32'(mq.size() == 0));
      chk("cyc overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("cyc tx_start", 32'(bus.tx_start), 32'(m_start));
      chk("cyc tx_din",   32'(bus.tx_din),   32'(m_din));
      chk("cyc tx_busy",  32'(bus.tx_busy),  32'(m_busy));
      if (32'(bus.count) > 32'(maxcnt)) maxcnt = 32'(bus.count);
      if (bus.tx_start) got.push_back(bus.tx_din);
    end
  end

  task automatic put(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // Done tick from the transmitter, then expect the next byte launched one cycle later.
  task automatic drain_expect(input logic [7:0] b);
    bus.tx_done_tick = 1'b1;
    @(negedge clk);
    bus.tx_done_tick = 1'b0;
    chk("drain tx_start", 32'(bus.tx_start), 32'd1);
    chk("drain tx_din",   32'(bus.tx_din),   32'(b));
    @(negedge clk);
  endtask

  task automatic final_tick();
    bus.tx_done_tick = 1'b1;
    @(negedge clk);
    bus.tx_done_tick = 1'b0;
    @(negedge clk);
    chk("idle tx_busy", 32'(bus.tx_busy), 32'd0);
    chk("idle empty",   32'(bus.empty),   32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    maxcnt = 0;
    reset  = 1'b1;
    bus.wr_en        = 1'b0;
    bus.wr_data      = 8'h00;
    bus.tx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("rst count",    32'(bus.count),    32'd0);
    chk("rst empty",    32'(bus.empty),    32'd1);
    chk("rst full",     32'(bus.full),     32'd0);
    chk("rst tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst tx_busy",  32'(bus.tx_busy),  32'd0);

    // Single byte: count 1 after one cycle, launch after two.
    repeat (6) @(negedge clk);
    put(8'hA5);
    chk("single count1", 32'(bus.count), 32'd1);
    chk("single nostart", 32'(bus.tx_start), 32'd0);
    @(negedge clk);
    chk("single start", 32'(bus.tx_start), 32'd1);
    chk("single din",   32'(bus.tx_din),   32'hA5);
    chk("single count0", 32'(bus.count),   32'd0);
    chk("single busy",  32'(bus.tx_busy),  32'd1);
    @(negedge clk);
    chk("single pulse", 32'(bus.tx_start), 32'd0);
    final_tick();

    // Burst of three.
    got.delete();
    put(8'h11); put(8'h22); put(8'h33);
    repeat (2) @(negedge clk);
    chk("burst launches", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("burst first", 32'(got[0]), 32'h11);
    drain_expect(8'h22);
    drain_expect(8'h33);
    final_tick();

    // Fill to 16 behind one launch, then overflow.
    got.delete();
    for (int k = 0; k < 17; k++) put(8'(k));
    chk("fill full",  32'(bus.full),     32'd1);
    chk("fill count", 32'(bus.count),    32'd16);
    chk("fill ovf",   32'(bus.overflow), 32'd0);
    chk("fill launches", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("fill first", 32'(got[0]), 32'h00);
    put(8'h11);
    chk("ovf set",   32'(bus.overflow), 32'd1);
    chk("ovf count", 32'(bus.count),    32'd16);
    for (int k = 1; k <= 16; k++) drain_expect(8'(k));
    final_tick();

    // Write and pop in the same cycle with two queued.
    put(8'hA0); put(8'hA1); put(8'hA2);
    chk("simul pre count", 32'(bus.count), 32'd2);
    bus.wr_en        = 1'b1;
    bus.wr_data      = 8'hA3;
    bus.tx_done_tick = 1'b1;
    @(negedge clk);
    bus.wr_en        = 1'b0;
    bus.tx_done_tick = 1'b0;
    chk("simul count", 32'(bus.count),    32'd2);
    chk("simul start", 32'(bus.tx_start), 32'd1);
    chk("simul din",   32'(bus.tx_din),   32'hA1);
    @(negedge clk);
    drain_expect(8'hA2);
    drain_expect(8'hA3);
    final_tick();

    // Wrap-around: 40 bytes paced by a transmitter answering 3 cycles after each launch.
    begin
      int sent;
      int cd;
      int post;
      sent   = 0;
      cd     = 0;
      post   = 0;
      maxcnt = 0;
      got.delete();
      for (int i = 0; i < 3000 && post < 8; i++) begin
        @(negedge clk);
        bus.wr_en        = 1'b0;
        bus.tx_done_tick = 1'b0;
        if (bus.tx_start) cd = 3;
        if (cd > 0) begin
          cd--;
          if (cd == 0) bus.tx_done_tick = 1'b1;
        end
        if (sent < 40 && mq.size() < 15) begin
          bus.wr_en   = 1'b1;
          bus.wr_data = 8'(sent);
          sent++;
        end
        if (got.size() == 40) post++;
      end
      bus.wr_en        = 1'b0;
      bus.tx_done_tick = 1'b0;
      @(negedge clk);
      chk("wrap launches", 32'(got.size()), 32'd40);
      for (int k = 0; k < 40 && k < got.size(); k++) chk("wrap order", 32'(got[k]), 32'(k));
      chk("wrap maxcount", 32'(maxcnt <= 16), 32'd1);
      chk("wrap idle", 32'(bus.tx_busy), 32'd0);
    end

    // Reset while busy with five queued bytes.
    for (int k = 0; k < 6; k++) put(8'hB0 + 8'(k));
    chk("rstmid count", 32'(bus.count),   32'd5);
    chk("rstmid busy",  32'(bus.tx_busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid count0",   32'(bus.count),    32'd0);
    chk("rstmid empty",    32'(bus.empty),    32'd1);
    chk("rstmid busy0",    32'(bus.tx_busy),  32'd0);
    chk("rstmid start0",   32'(bus.tx_start), 32'd0);
    chk("rstmid din0",     32'(bus.tx_din),   32'd0);
    chk("rstmid overflow", 32'(bus.overflow), 32'd0);
    got.delete();
    bus.tx_done_tick = 1'b1;
    @(negedge clk);
    bus.tx_done_tick = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray tick launches", 32'(got.size()), 32'd0);
    chk("stray tick busy",     32'(bus.tx_busy), 32'd0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
